aes_key_expand_wddl: RTL

AES_KEY_EXPAND_WDDL -- requirements
Module: aes_key_expand_wddl

---
 rtl/aes_wddl_pkg.sv | 55 +++++
 rtl/aes_sbox_wddl.sv | 15 +
 rtl/aes_key_expand_wddl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aes_wddl_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the dual-rail key expander.
package aes_wddl_pkg;

  localparam int N_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_HOLD
  } state_e;

  // Round constants for rounds 1..10, stored at index round-1.
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r - 4'd1];
    return v;
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox_wddl.sv
// Dual-rail combinational S-box byte: true rail maps the true input, complement
// rail is derived only from the complement input.
module aes_sbox_wddl
  import aes_wddl_pkg::*;
(
  input  logic [7:0] in_t,
  input  logic [7:0] in_n,
  output logic [7:0] out_t,
  output logic [7:0] out_n
);

  assign out_t = sbox_fwd(in_t);
  assign out_n = ~sbox_fwd(~in_n);

endmodule

// File: rtl/aes_key_expand_wddl.sv
// AES-128 key expander, one round key per cycle, carried on true and complement rails.
module aes_key_expand_wddl
  import aes_wddl_pkg::*;
#(
  parameter bit CHECK_RAILS = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic [127:0] key_n,
  output logic [31:0]  w0,
  output logic [31:0]  w1,
  output logic [31:0]  w2,
  output logic [31:0]  w3,
  output logic [31:0]  w0_n,
  output logic [31:0]  w1_n,
  output logic [31:0]  w2_n,
  output logic [31:0]  w3_n,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  output logic         rail_err
);

  state_e            state_q, state_d;
  logic [3:0][31:0]  w_q, wn_q, w_d, wn_d;
  logic [3:0][31:0]  nxt_t, nxt_n;
  logic [3:0]        round_q, round_d;
  logic              done_q, done_d;
  logic              rerr_q, rerr_d;
  logic [31:0]       rot_t, rot_n, sub_t, sub_n, t_t, t_n, rcon_w;

  assign rot_t = {w_q[3][23:0], w_q[3][31:24]};
  assign rot_n = {wn_q[3][23:0], wn_q[3][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox_wddl u_sbox (
      .in_t  (rot_t[8*g +: 8]),
      .in_n  (rot_n[8*g +: 8]),
      .out_t (sub_t[8*g +: 8]),
      .out_n (sub_n[8*g +: 8])
    );
  end

  // XOR with a constant commutes through complement, so both rails add Rcon directly.
  assign rcon_w = {rcon_of(round_q + 4'd1), 24'h000000};
  assign t_t    = sub_t ^ rcon_w;
  assign t_n    = sub_n ^ rcon_w;

  // Word chain per rail; complement rail uses ~(a_n ^ b_n) == ~(a ^ b).
  always_comb begin
    nxt_t[0] = w_q[0] ^ t_t;
    nxt_n[0] = ~(wn_q[0] ^ t_n);
    for (int i = 1; i < 4; i++) begin
      nxt_t[i] = w_q[i] ^ nxt_t[i-1];
      nxt_n[i] = ~(wn_q[i] ^ nxt_n[i-1]);
    end
  end

  // Next-state: a load wins in every state; EXPAND steps one round per cycle.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    wn_d    = wn_q;
    round_d = round_q;
    done_d  = 1'b0;
    rerr_d  = rerr_q;
    if (kld) begin
      for (int i = 0; i < 4; i++) begin
        w_d[i]  = key[127 - 32*i -: 32];
        wn_d[i] = key_n[127 - 32*i -: 32];
      end
      round_d = 4'd0;
      state_d = ST_EXPAND;
      rerr_d  = CHECK_RAILS && ((key ^ key_n) != {128{1'b1}});
    end else begin
      case (state_q)
        ST_EXPAND: begin
          w_d     = nxt_t;
          wn_d    = nxt_n;
          round_d = round_q + 4'd1;
          if (round_q == 4'(N_ROUNDS - 1)) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end
        end
        ST_IDLE, ST_HOLD: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register; reset returns both rails to the all-zero precharge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      wn_q    <= '0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      wn_q    <= wn_d;
      round_q <= round_d;
      done_q  <= done_d;
      rerr_q  <= rerr_d;
    end
  end

  assign w0       = w_q[0];
  assign w1       = w_q[1];
  assign w2       = w_q[2];
  assign w3       = w_q[3];
  assign w0_n     = wn_q[0];
  assign w1_n     = wn_q[1];
  assign w2_n     = wn_q[2];
  assign w3_n     = wn_q[3];
  assign round    = round_q;
  assign busy     = (state_q == ST_EXPAND);
  assign done     = done_q;
  assign rail_err = CHECK_RAILS ? rerr_q : 1'b0;

endmodule
